// File: rtl/imu_offset_cal.sv
// imu_offset_cal: per-channel IMU offset calibration and correction.
// Calibration averages 2^CAL_LOG2 sample sets. In RUN, each sample has the
// learned offset subtracted from it.
// Build option: define OFFSET_SAT_EN to saturate corrected outputs to the
// W-bit signed range. By default the outputs wrap in two's complement.
module imu_offset_cal #(
  parameter int NCH      = 3,
  parameter int W        = 16,
  parameter int CAL_LOG2 = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt_cal,
  input  logic             smpl_vld,
  input  logic [NCH*W-1:0] smpl,
  output logic             out_vld,
  output logic [NCH*W-1:0] out,
  output logic             cal_done,
  output logic             busy
);

  localparam int AW = W + CAL_LOG2;
  localparam logic [CAL_LOG2-1:0] CntOne = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CAL = 2'd1, RUN = 2'd2} state_t;

  state_t              r_state, w_state_d;
  logic [AW-1:0]       r_acc     [NCH];
  logic [AW-1:0]       w_acc_sum [NCH];
  logic [W:0]          w_diff    [NCH];
  logic [W-1:0]        r_off     [NCH];
  logic [CAL_LOG2-1:0] r_cnt;
  logic                r_out_vld, r_cal_done;
  logic [NCH*W-1:0]    r_out, w_out_d;
  logic                w_acc_clr, w_acc_en, w_cal_last, w_out_en;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_d;
  end

  // Next-state and datapath control; strt_cal overrides any sample in the same cycle
  always_comb begin
    w_state_d  = r_state;
    w_acc_clr  = 1'b0;
    w_acc_en   = 1'b0;
    w_cal_last = 1'b0;
    w_out_en   = 1'b0;
    if (strt_cal) begin
      w_state_d = CAL;
      w_acc_clr = 1'b1;
    end else begin
      case (r_state)
        IDLE, RUN: w_out_en = smpl_vld;
        CAL: begin
          if (smpl_vld) begin
            w_acc_en = 1'b1;
            if (r_cnt == {CAL_LOG2{1'b1}}) begin
              w_cal_last = 1'b1;
              w_state_d  = RUN;
            end
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  // Accumulate sign-extended samples, then form the corrected outputs at W+1 bits
  always_comb begin
    w_out_d = '0;
    for (int k = 0; k < NCH; k++) begin
      w_acc_sum[k] = r_acc[k] + {{CAL_LOG2{smpl[k*W+W-1]}}, smpl[k*W +: W]};
      w_diff[k]    = {smpl[k*W+W-1], smpl[k*W +: W]} - {r_off[k][W-1], r_off[k]};
`ifdef OFFSET_SAT_EN
      if (w_diff[k][W] != w_diff[k][W-1]) begin
        w_out_d[k*W +: W] = w_diff[k][W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
        w_out_d[k*W +: W] = w_diff[k][W-1:0];
      end
`else
      w_out_d[k*W +: W] = w_diff[k][W-1:0];
`endif
    end
  end

  // Accumulators, sample counter, offsets and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        r_acc[k] <= '0;
        r_off[k] <= '0;
      end
      r_cnt      <= '0;
      r_cal_done <= 1'b0;
      r_out      <= '0;
      r_out_vld  <= 1'b0;
    end else begin
      if (w_acc_clr) begin
        for (int k = 0; k < NCH; k++) r_acc[k] <= '0;
        r_cnt      <= '0;
        r_cal_done <= 1'b0;
      end else if (w_acc_en) begin
        for (int k = 0; k < NCH; k++) r_acc[k] <= w_acc_sum[k];
        r_cnt <= r_cnt + CntOne;
      end
      // Upper W bits of the final sum are the arithmetic shift by CAL_LOG2
      if (w_cal_last) begin
        for (int k = 0; k < NCH; k++) r_off[k] <= w_acc_sum[k][AW-1:CAL_LOG2];
        r_cal_done <= 1'b1;
      end
      if (w_out_en) r_out <= w_out_d;
      r_out_vld <= w_out_en;
    end
  end

  assign out      = r_out;
  assign out_vld  = r_out_vld;
  assign cal_done = r_cal_done;
  assign busy     = (r_state == CAL);

endmodule

// File: tb/tb_imu_offset_cal.sv
// Directed self-checking bench for imu_offset_cal (NCH=3, W=16, CAL_LOG2=4).
module tb_imu_offset_cal;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt_cal = 1'b0;
  logic        smpl_vld = 1'b0;
  logic [47:0] smpl = '0;
  logic        out_vld, cal_done, busy;
  logic [47:0] out;
  logic [47:0] exp_v;
  int          n_pass = 0;
  int          n_total = 0;

  imu_offset_cal #(.NCH(3), .W(16), .CAL_LOG2(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .strt_cal (strt_cal),
    .smpl_vld (smpl_vld),
    .smpl     (smpl),
    .out_vld  (out_vld),
    .out      (out),
    .cal_done (cal_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pack(input int a, input int b, input int c);
    return {c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] v);
    smpl     = v;
    smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
  endtask

  task automatic start();
    strt_cal = 1'b1;
    tick();
    strt_cal = 1'b0;
  endtask

  task automatic test_reset();
    smpl = pack(1, 2, 3);
    for (int i = 0; i < 4; i++) begin
      smpl_vld = i[0];
      tick();
      n_total++;
      if (out_vld !== 1'b0) $display("FAIL reset_outvld cyc%0d got %b want 0", i, out_vld);
      else n_pass++;
    end
    n_total++;
    if ({out, cal_done, busy} !== 50'd0)
      $display("FAIL reset_outs got out=%h cal_done=%b busy=%b want 0", out, cal_done, busy);
    else n_pass++;
    smpl_vld = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic test_idle();
    exp_v = pack(100, -200, 300);
    send(exp_v);
    n_total++;
    if (out_vld !== 1'b1 || out !== exp_v)
      $display("FAIL idle_pass got vld=%b out=%h want 1 %h", out_vld, out, exp_v);
    else n_pass++;
    tick();
    n_total++;
    if (out_vld !== 1'b0) $display("FAIL idle_pulse got %b want 0", out_vld);
    else n_pass++;
  endtask

  task automatic test_cal();
    start();
    n_total++;
    if (busy !== 1'b1 || cal_done !== 1'b0)
      $display("FAIL cal_start got busy=%b done=%b want 1 0", busy, cal_done);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      send(pack(10, -7, 1000));
      if (i < 15) begin
        n_total++;
        if ({cal_done, busy, out_vld} !== 3'b010)
          $display("FAIL cal_progress smp%0d got done/busy/vld=%b%b%b want 010", i, cal_done,
                   busy, out_vld);
        else n_pass++;
      end
    end
    n_total++;
    if ({cal_done, busy, out_vld} !== 3'b100)
      $display("FAIL cal_finish got done/busy/vld=%b%b%b want 100", cal_done, busy, out_vld);
    else n_pass++;
  endtask

  task automatic test_run();
    send(pack(20, 0, 1000));
    exp_v = pack(10, 7, 0);
    n_total++;
    if (out_vld !== 1'b1 || out !== exp_v)
      $display("FAIL run_corr got vld=%b out=%h want 1 %h", out_vld, out, exp_v);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send(pack(0, 0, 0));
    exp_v = pack(-10, 7, -1000);
    n_total++;
    if (out_vld !== 1'b1 || out !== exp_v)
      $display("FAIL b2b_first got vld=%b out=%h want 1 %h", out_vld, out, exp_v);
    else n_pass++;
    send(pack(-5, -7, 2000));
    exp_v = pack(-15, 0, 1000);
    n_total++;
    if (out_vld !== 1'b1 || out !== exp_v)
      $display("FAIL b2b_second got vld=%b out=%h want 1 %h", out_vld, out, exp_v);
    else n_pass++;
    tick();
    n_total++;
    if (out_vld !== 1'b0 || cal_done !== 1'b1)
      $display("FAIL b2b_idle got vld=%b done=%b want 0 1", out_vld, cal_done);
    else n_pass++;
  endtask

  task automatic test_restart();
    start();
    n_total++;
    if (cal_done !== 1'b0) $display("FAIL restart_clr_done got %b want 0", cal_done);
    else n_pass++;
    for (int i = 0; i < 5; i++) send(pack(4, 4, 4));
    // Restart coincident with a sample: the sample must be dropped
    strt_cal = 1'b1;
    smpl_vld = 1'b1;
    smpl     = pack(1000, 1000, 1000);
    tick();
    strt_cal = 1'b0;
    smpl_vld = 1'b0;
    n_total++;
    if (out_vld !== 1'b0 || busy !== 1'b1)
      $display("FAIL restart_coincident got vld=%b busy=%b want 0 1", out_vld, busy);
    else n_pass++;
    for (int i = 0; i < 15; i++) send(pack(2, 2, 2));
    n_total++;
    if (cal_done !== 1'b0 || busy !== 1'b1)
      $display("FAIL restart_15 got done=%b busy=%b want 0 1", cal_done, busy);
    else n_pass++;
    send(pack(2, 2, 2));
    n_total++;
    if (cal_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL restart_16 got done=%b busy=%b want 1 0", cal_done, busy);
    else n_pass++;
    send(pack(2, 3, 4));
    exp_v = pack(0, 1, 2);
    n_total++;
    if (out_vld !== 1'b1 || out !== exp_v)
      $display("FAIL restart_offs got vld=%b out=%h want 1 %h", out_vld, out, exp_v);
    else n_pass++;
  endtask

  task automatic test_sat();
    start();
    // ch1 sums to -15 -> offset floor(-15/16) = -1
    for (int i = 0; i < 16; i++) send(pack(1000, (i == 0) ? 0 : -1, -1000));
    n_total++;
    if (cal_done !== 1'b1) $display("FAIL sat_cal got done=%b want 1", cal_done);
    else n_pass++;
    send(pack(-32000, 0, 32000));
`ifdef OFFSET_SAT_EN
    exp_v = pack(-32768, 1, 32767);
`else
    exp_v = pack(32536, 1, -32536);
`endif
    n_total++;
    if (out_vld !== 1'b1 || out !== exp_v)
      $display("FAIL sat_range got vld=%b out=%h want 1 %h", out_vld, out, exp_v);
    else n_pass++;
  endtask

  task automatic test_reset_mid_cal();
    start();
    for (int i = 0; i < 3; i++) send(pack(50, 50, 50));
    rst = 1'b1;
    #1;
    n_total++;
    if ({busy, cal_done, out_vld, out} !== 51'd0)
      $display("FAIL rst_async got busy=%b done=%b vld=%b out=%h want 0", busy, cal_done,
               out_vld, out);
    else n_pass++;
    tick();
    rst = 1'b0;
    exp_v = pack(7, -8, 9);
    send(exp_v);
    n_total++;
    if (out_vld !== 1'b1 || out !== exp_v || busy !== 1'b0)
      $display("FAIL rst_idle_pass got vld=%b out=%h busy=%b want 1 %h 0", out_vld, out, busy,
               exp_v);
    else n_pass++;
  endtask

  initial begin
    tick();
    test_reset();
    test_idle();
    test_cal();
    test_run();
    test_back_to_back();
    test_restart();
    test_sat();
    test_reset_mid_cal();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
